// File: rtl/seven_seg_scanner_pkg.sv
// Shared display constants and helpers for the calculator display paths.
// The package name is shared with the other display consumers.
package calc_disp_pkg;

    typedef logic [3:0] disp_code_t;

    localparam disp_code_t CODE_BLANK = 4'hE;
    localparam disp_code_t CODE_NEG   = 4'hF;

    // Segment order {g,f,e,d,c,b,a}; 0 lights the segment
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned refresh_hz);
        if (refresh_hz == 32'd0) begin
            return 32'd0;
        end else begin
            return clk_hz / refresh_hz;
        end
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Code/strobe inputs and display pin bundle of the 4-digit scanner.
interface seven_seg_scanner_if;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] dp_in;
    logic       load;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    modport master (
        output digit0, digit1, digit2, digit3, dp_in, load, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  digit0, digit1, digit2, digit3, dp_in, load, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner_seg7_decode.sv
// Combinational display-code to active-low 7-segment pattern decoder.
module seg7_decode
    import calc_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Code to segment pattern lookup
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA, 4'hB, 4'hC, 4'hD: seg = SEG_E;
            CODE_BLANK: seg = SEG_BLANK;
            CODE_NEG:   seg = SEG_MINUS;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode scanner; new codes take effect only at frame wrap.
module seven_seg_scanner
    import calc_disp_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 4000,
    parameter int unsigned BLANK_CYC  = 2
) (
    input logic clk,
    input logic rst_n,
    seven_seg_scanner_if.slave bus
);

    localparam int unsigned DIV = calc_div(CLK_HZ, REFRESH_HZ);
    localparam int unsigned PW  = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 32'd1);
    localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);

    if (DIV < 32'd4 || BLANK_CYC >= DIV) begin : g_param_check
        $error("seven_seg_scanner: need DIV >= 4 and BLANK_CYC < DIV");
    end

    logic [PW-1:0]        pre_r;
    logic [1:0]           idx_r;
    logic [3:0][3:0]      pend_r;
    logic [3:0][3:0]      act_r;
    logic [3:0]           pend_dp_r;
    logic [3:0]           act_dp_r;
    logic [3:0]           an_r;
    logic [6:0]           seg_r;
    logic                 dp_r;
    logic                 fd_r;

    logic                 tick_s;
    logic                 wrap_s;
    logic [3:0][3:0]      load_codes_s;
    logic [3:0]           lz_s;
    logic [3:0]           dec_code_s;
    logic [6:0]           dec_seg_s;
    logic [3:0]           an_nxt_s;
    logic [6:0]           seg_nxt_s;
    logic                 dp_nxt_s;

    assign tick_s       = (pre_r == PRE_LAST);
    assign wrap_s       = tick_s && (idx_r == 2'd3);
    assign load_codes_s = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};

    // Slot timing: prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= '0;
            idx_r <= 2'd0;
        end else if (tick_s) begin
            pre_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            pre_r <= pre_r + PW'(1);
        end
    end

    // Pending codes follow load; active codes swap only at the frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r    <= {4{CODE_BLANK}};
            act_r     <= {4{CODE_BLANK}};
            pend_dp_r <= 4'h0;
            act_dp_r  <= 4'h0;
        end else begin
            if (bus.load) begin
                pend_r    <= load_codes_s;
                pend_dp_r <= bus.dp_in;
            end
            if (wrap_s) begin
                act_r    <= bus.load ? load_codes_s : pend_r;
                act_dp_r <= bus.load ? bus.dp_in    : pend_dp_r;
            end
        end
    end

    // Leading-zero mask: a digit blanks only if it and every digit to its left is 0
    always_comb begin
        lz_s    = 4'h0;
        lz_s[3] = bus.blank_lz && (act_r[3] == 4'h0);
        lz_s[2] = lz_s[3] && (act_r[2] == 4'h0);
        lz_s[1] = lz_s[2] && (act_r[1] == 4'h0);
        lz_s[0] = 1'b0;
        dec_code_s = lz_s[idx_r] ? CODE_BLANK : act_r[idx_r];
    end

    seg7_decode u_decode (
        .code (dec_code_s),
        .seg  (dec_seg_s)
    );

    // Next pin values: anti-ghost gap at slot start, then the selected digit
    always_comb begin
        an_nxt_s  = 4'hF;
        seg_nxt_s = SEG_BLANK;
        dp_nxt_s  = 1'b1;
        if (pre_r >= PRE_BLANK) begin
            an_nxt_s[idx_r] = 1'b0;
            seg_nxt_s       = dec_seg_s;
            dp_nxt_s        = ~act_dp_r[idx_r];
        end else begin
            an_nxt_s  = 4'hF;
            seg_nxt_s = SEG_BLANK;
            dp_nxt_s  = 1'b1;
        end
    end

    // Registered display pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r  <= 4'hF;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
            fd_r  <= 1'b0;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            dp_r  <= dp_nxt_s;
            fd_r  <= wrap_s;
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_done = fd_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a cycle-count based display model.
module tb_seven_seg_scanner;

    localparam int DIV       = 4;
    localparam int FRAME     = 4 * DIV;
    localparam int BLANK_CYC = 1;
    localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h7F, 7'h3F};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    seven_seg_scanner_if bus();

    seven_seg_scanner #(.CLK_HZ(16), .REFRESH_HZ(4), .BLANK_CYC(BLANK_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] in_codes;
    assign in_codes = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};

    // Model state: n = rising edges since reset; pins lag the count by one edge
    int          n = 0;
    logic [15:0] m_pend = 16'hEEEE;
    logic [15:0] m_act  = 16'hEEEE;
    logic [3:0]  m_pdp  = 4'h0;
    logic [3:0]  m_adp  = 4'h0;
    logic [11:0] exp_pins = {4'hF, 7'h7F, 1'b1};
    logic        exp_fd   = 1'b0;

    function automatic logic [11:0] ref_pins(input int cnt, input logic [15:0] codes,
                                             input logic [3:0] dps, input logic blz);
        int idx;
        logic blanked;
        logic [3:0] code;
        idx = (cnt / DIV) % 4;
        if ((cnt % DIV) < BLANK_CYC) return {4'hF, 7'h7F, 1'b1};
        blanked = blz && (idx > 0);
        for (int j = idx; j < 4; j++) begin
            if (codes[4*j +: 4] != 4'h0) blanked = 1'b0;
        end
        code = codes[4*idx +: 4];
        return {~(4'b0001 << idx), (blanked ? 7'h7F : FONT[code]), ~dps[idx]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n        <= 0;
            m_pend   <= 16'hEEEE;
            m_act    <= 16'hEEEE;
            m_pdp    <= 4'h0;
            m_adp    <= 4'h0;
            exp_pins <= {4'hF, 7'h7F, 1'b1};
            exp_fd   <= 1'b0;
        end else begin
            exp_pins <= ref_pins(n, m_act, m_adp, bus.blank_lz);
            exp_fd   <= ((n % FRAME) == FRAME - 1);
            n        <= n + 1;
            if (bus.load) begin
                m_pend <= in_codes;
                m_pdp  <= bus.dp_in;
            end
            if ((n % FRAME) == FRAME - 1) begin
                m_act <= bus.load ? in_codes : m_pend;
                m_adp <= bus.load ? bus.dp_in : m_pdp;
            end
        end
    end

    int          n_pass = 0;
    int          n_total = 0;
    logic        chk_en = 1'b1;
    int          lit_id = 0;
    int          lit_seen = 0;
    int          lit_n = 0;
    logic [12:0] lit_val = '0;
    string       lit_name = "";

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_total++;
                if ({bus.an, bus.seg, bus.dp} !== exp_pins || bus.frame_done !== exp_fd) begin
                    $display("FAIL pins n=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                             n, bus.an, bus.seg, bus.dp, bus.frame_done,
                             exp_pins[11:8], exp_pins[7:1], exp_pins[0], exp_fd);
                end else begin
                    n_pass++;
                end
                if (lit_id != lit_seen && n >= lit_n) begin
                    lit_seen = lit_id;
                    n_total += 2;
                    if (n != lit_n || {bus.an, bus.seg, bus.dp, bus.frame_done} !== lit_val) begin
                        $display("FAIL %s dut n=%0d/%0d got {an,seg,dp,fd}=%h want %h",
                                 lit_name, n, lit_n, {bus.an, bus.seg, bus.dp, bus.frame_done}, lit_val);
                    end else begin
                        n_pass++;
                    end
                    if ({exp_pins, exp_fd} !== lit_val) begin
                        $display("FAIL %s model got %h want %h", lit_name, {exp_pins, exp_fd}, lit_val);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    task automatic wait_n(input int target);
        for (int k = 0; k < 2000 && n != target; k++) begin
            @(negedge clk);
            #1;
        end
        if (n != target) begin
            $display("FAIL wait_n timeout got n=%0d want %0d", n, target);
            $fatal(1, "timeout");
        end
    endtask

    task automatic expect_at(input int at, input logic [3:0] an_e, input logic [6:0] seg_e,
                             input logic dp_e, input logic fd_e, input string nm);
        lit_n    = at;
        lit_val  = {an_e, seg_e, dp_e, fd_e};
        lit_name = nm;
        lit_id++;
        for (int k = 0; k < 2000 && lit_seen != lit_id; k++) begin
            @(negedge clk);
            #1;
        end
        if (lit_seen != lit_id) begin
            $display("FAIL %s timeout got n=%0d want %0d", nm, n, at);
            $fatal(1, "timeout");
        end
    endtask

    task automatic do_load(input logic [15:0] codes, input logic [3:0] dps);
        {bus.digit3, bus.digit2, bus.digit1, bus.digit0} = codes;
        bus.dp_in = dps;
        bus.load  = 1'b1;
        @(negedge clk);
        #1;
        bus.load  = 1'b0;
    endtask

    initial begin : main
        {bus.digit3, bus.digit2, bus.digit1, bus.digit0} = 16'h0000;
        bus.dp_in    = 4'h0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        expect_at(0, 4'hF, 7'h7F, 1'b1, 1'b0, "reset_hold");
        rst_n = 1'b1;
        do_load(16'h3210, 4'h0);
        expect_at(2,  4'hE, 7'h7F, 1'b1, 1'b0, "pre_wrap_blank");
        expect_at(16, 4'h7, 7'h7F, 1'b1, 1'b1, "first_wrap");
        expect_at(17, 4'hF, 7'h7F, 1'b1, 1'b0, "slot_gap");
        expect_at(18, 4'hE, 7'h40, 1'b1, 1'b0, "scan_d0");
        expect_at(22, 4'hD, 7'h79, 1'b1, 1'b0, "scan_d1");
        wait_n(24);
        do_load(16'hFAE9, 4'h0);
        expect_at(34, 4'hE, 7'h10, 1'b1, 1'b0, "dec_9");
        expect_at(38, 4'hD, 7'h7F, 1'b1, 1'b0, "dec_blank");
        expect_at(42, 4'hB, 7'h06, 1'b1, 1'b0, "dec_err");
        expect_at(46, 4'h7, 7'h3F, 1'b1, 1'b0, "dec_minus");
        wait_n(48);
        do_load(16'h1234, 4'h0);
        wait_n(69);
        do_load(16'h5678, 4'h0);
        expect_at(74, 4'hB, 7'h24, 1'b1, 1'b0, "tear_d2");
        expect_at(78, 4'h7, 7'h79, 1'b1, 1'b0, "tear_d3");
        expect_at(82, 4'hE, 7'h00, 1'b1, 1'b0, "next_d0");
        expect_at(86, 4'hD, 7'h78, 1'b1, 1'b0, "next_d1");
        wait_n(95);
        do_load(16'h0003, 4'h0);
        expect_at(98,  4'hE, 7'h30, 1'b1, 1'b0, "wrap_load");
        expect_at(102, 4'hD, 7'h40, 1'b1, 1'b0, "zero_shown");
        wait_n(103);
        bus.blank_lz = 1'b1;
        wait_n(104);
        do_load(16'h0000, 4'h8);
        expect_at(114, 4'hE, 7'h40, 1'b1, 1'b0, "lz_d0_kept");
        expect_at(118, 4'hD, 7'h7F, 1'b1, 1'b0, "lz_d1_blank");
        wait_n(120);
        do_load(16'h0F07, 4'h0);
        expect_at(126, 4'h7, 7'h7F, 1'b0, 1'b0, "lz_dp_kept");
        expect_at(130, 4'hE, 7'h78, 1'b1, 1'b0, "lz2_d0");
        expect_at(134, 4'hD, 7'h40, 1'b1, 1'b0, "lz2_d1_zero");
        expect_at(138, 4'hB, 7'h3F, 1'b1, 1'b0, "lz2_minus");
        expect_at(142, 4'h7, 7'h7F, 1'b1, 1'b0, "lz2_d3_blank");
        wait_n(143);
        bus.blank_lz = 1'b0;
        expect_at(158, 4'h7, 7'h40, 1'b1, 1'b0, "lz_off");
        wait_n(161);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expect_at(0, 4'hF, 7'h7F, 1'b1, 1'b0, "async_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (i == 1000) begin
                #2;
                rst_n = 1'b0;
                bus.load = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                bus.load = ($urandom_range(0, 4) == 0);
                {bus.digit3, bus.digit2, bus.digit1, bus.digit0} = 16'($urandom);
                bus.dp_in = 4'($urandom);
                if ($urandom_range(0, 49) == 0) bus.blank_lz = ~bus.blank_lz;
            end
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
